frac_baud_gen: RTL
==================

# frac_baud_gen

Fractional baud-rate generator for the UART path. It produces single-cycle clock-enable ticks in the system clock domain; it does not generate a derived clock. It supports a runtime-programmable divisor with integer and fractional parts, 16x (parametrised) oversampling ticks, and a phase restart for RX start-bit alignment. UART TX/RX shift logic consumes `os_tick`, `mid_tick` and `baud_tick` as enables.

## Interface
- `INT_WIDTH`, 16: width of the integer divisor part, in system clocks per oversample tick.
- `FRAC_WIDTH`, 4: width of the fractional divisor part, in units of 2^-FRAC_WIDTH clock.
- `OVERSAMPLE`, 16: oversample ticks per baud period. Must be even and at least 2.
- `DEF_INT`, 27: integer divisor after reset. Must be at least 2.
- `DEF_FRAC`, 0: fractional divisor after reset.
- `clock` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: run enable. Counters hold while low.
- `load` in 1: latch `div_int`/`div_frac` into the shadow registers.
- `div_int` in INT_WIDTH: new integer divisor.
- `div_frac` in FRAC_WIDTH: new fractional divisor.
- `sync` in 1: restart phase (period, accumulator and oversample counter).
- `os_tick` out 1: one-cycle pulse per oversample period.
- `mid_tick` out 1: one-cycle pulse at the bit centre.
- `baud_tick` out 1: one-cycle pulse per baud period.
- `os_phase` out $clog2(OVERSAMPLE): current oversample index.

## Operation
- State:
  - shadow `int_r`/`frac_r`
  - down-counter `cnt` (INT_WIDTH)
  - phase accumulator `acc` (FRAC_WIDTH)
  - oversample counter `os_cnt`
  - registered tick outputs
- Effective integer `eint` = max(`int_r`, 2). A `div_int` of 0 or 1 is clamped to 2. There is no error flag.
- Reset (asynchronous, `rst`=0):
  - `int_r`=DEF_INT, `frac_r`=DEF_FRAC
  - `cnt`=DEF_INT-1, `acc`=0, `os_cnt`=0
  - `os_tick`=`mid_tick`=`baud_tick`=0
  - `os_phase`=0
- `load`=1 on an edge: shadow registers take `div_int`/`div_frac`. The running period is not shortened. The new value applies at the next reload.
- Reload uses forwarded values: if `load` coincides with a reload edge or a `sync` edge, the incoming divisor is used.
- Priority is `sync` > `en` > hold.
- `sync`=1 on an edge:
  - `cnt` = `eint`-1, `acc`=0, `os_cnt`=0
  - all ticks 0
  - this applies regardless of `en`
- `en`=1, `sync`=0, `cnt`≠0: `cnt` decrements and ticks are 0.
- `en`=1, `sync`=0, `cnt`=0 (the reload edge):
  - {carry, acc_next} = `acc` + `frac_r` (FRAC_WIDTH+1 bits)
  - `cnt` = `eint` - 1 + carry, and `acc` = acc_next
  - `os_tick` = 1
  - `mid_tick` = 1 if `os_cnt` == OVERSAMPLE/2-1
  - `baud_tick` = 1 if `os_cnt` == OVERSAMPLE-1
  - `os_cnt` wraps to 0 after OVERSAMPLE-1, otherwise increments
- `en`=0: all state holds and all ticks are 0. A pulse is never stretched.
- Average oversample period is `eint` + `frac_r`/2^FRAC_WIDTH clocks. Individual periods are `eint` or `eint`+1.
- `os_phase` = `os_cnt`, registered.

## Timing
- All outputs are registered. Ticks are high for exactly one cycle.
- Edge numbering: edge 1 is the first rising edge with `en`=1 after reset release or after a `sync` edge.
- With `frac_r`=0 and divisor N:
  - `os_tick` rises after edges N, 2N, 3N, ...
  - `baud_tick` rises after edge OVERSAMPLE·N
  - `mid_tick` rises after edge (OVERSAMPLE/2)·N
- Minimum tick spacing is 2 clocks, so the ticks are never high continuously.
- Dropping `en` mid-period freezes `cnt`. The remaining cycles resume when `en` returns, so no enabled cycle is lost or gained.
- Reset mid-period takes effect immediately (asynchronous) and kills any pulse in flight.

## Test plan
- Reset defaults (DEF_INT=27, DEF_FRAC=0, `en`=1): `os_tick` every 27 cycles, first after edge 27. `mid_tick` after edge 216. `baud_tick` after edge 432 and every 432 cycles after that. `os_phase` cycles 0..15.
- Fractional divisor (load `div_int`=10, `div_frac`=4, then `sync`): `os_tick` after edges 10, 20, 30, 40, 51, 61, 71, 81, 92. `baud_tick` after edge 163. The pattern then repeats every 164 clocks.
- Clamp (`div_int`=1, `div_frac`=0): `os_tick` every 2 cycles. `div_int`=0 gives the same result.
- Load mid-period (running at 27, `load` 10 at `cnt`=15): the current period still completes at 27 cycles. The following periods are 10 cycles. With `load` on the reload edge itself, the very next period is 10.
- `sync` with `en`: `sync` pulse at `os_phase`=7 → `os_phase`=0 and ticks suppressed. The next `os_tick` is exactly `eint` edges later. `en` low for 5 cycles mid-period delays the tick by exactly 5 cycles.
- Asynchronous reset during a `baud_tick` cycle: all outputs are 0 immediately. After release, behaviour matches the first scenario.

Source files
------------

// File: rtl/frac_baud_gen.sv
// frac_baud_gen: fractional UART baud-rate tick generator.
// Emits oversample, bit-centre and baud clock-enables in the clk domain.
module frac_baud_gen #(
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_INT    = 27,
  parameter int DEF_FRAC   = 0
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [INT_WIDTH-1:0]          div_int,
  input  logic [FRAC_WIDTH-1:0]         div_frac,
  input  logic                          sync,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE/2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [INT_WIDTH-1:0] MIN_INT = INT_WIDTH'(2);
  localparam logic [INT_WIDTH-1:0] ONE     = INT_WIDTH'(1);

  logic [INT_WIDTH-1:0]  int_r;
  logic [INT_WIDTH-1:0]  int_use;
  logic [INT_WIDTH-1:0]  eint;
  logic [INT_WIDTH-1:0]  cnt;
  logic [INT_WIDTH-1:0]  cnt_rl;
  logic [FRAC_WIDTH-1:0] frac_r;
  logic [FRAC_WIDTH-1:0] frac_use;
  logic [FRAC_WIDTH-1:0] acc;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic [OSW-1:0]        os_cnt;

  // Forward a same-cycle load so a reload or restart uses the new divisor.
  always_comb begin
    int_use  = load ? div_int : int_r;
    frac_use = load ? div_frac : frac_r;
    eint     = (int_use < MIN_INT) ? MIN_INT : int_use;
    acc_sum  = {1'b0, acc} + {1'b0, frac_use};
    cnt_rl   = eint - ONE + INT_WIDTH'(acc_sum[FRAC_WIDTH]);
  end

  // Shadow divisor registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      int_r  <= INT_WIDTH'(DEF_INT);
      frac_r <= FRAC_WIDTH'(DEF_FRAC);
    end else if (load) begin
      int_r  <= div_int;
      frac_r <= div_frac;
    end
  end

  // Period counter, phase accumulator, oversample index and tick flops.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt       <= INT_WIDTH'(DEF_INT - 1);
      acc       <= '0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
      if (sync) begin
        cnt    <= eint - ONE;
        acc    <= '0;
        os_cnt <= '0;
      end else if (en) begin
        if (cnt == '0) begin
          cnt       <= cnt_rl;
          acc       <= acc_sum[FRAC_WIDTH-1:0];
          os_tick   <= 1'b1;
          mid_tick  <= (os_cnt == OS_MID);
          baud_tick <= (os_cnt == OS_LAST);
          if (os_cnt == OS_LAST)
            os_cnt <= '0;
          else
            os_cnt <= os_cnt + OSW'(1);
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

  assign os_phase = os_cnt;

endmodule
